// File: rtl/multicycle_datapath_pkg.sv
// Shared encodings, field positions and ALU for the multicycle datapath.
// REG_ZERO_HARDWIRE_EN (optional) is consumed by regfile_2r1w.
package multicycle_datapath_pkg;

   localparam int DATA_W_DEF = 32;

   localparam int OP_MSB  = 31;
   localparam int OP_LSB  = 26;
   localparam int RD_LSB  = 21;
   localparam int RS_LSB  = 16;
   localparam int RT_LSB  = 11;
   localparam int IMM_MSB = 15;
   localparam int IMM_LSB = 0;
   localparam int JT_W    = 26;

   typedef enum logic [3:0] {
      ALU_PASS = 4'b0000,
      ALU_NOT  = 4'b0001,
      ALU_ADD  = 4'b0010,
      ALU_SUB  = 4'b0011,
      ALU_OR   = 4'b0100,
      ALU_AND  = 4'b0101,
      ALU_XOR  = 4'b0110,
      ALU_SLT  = 4'b0111
   } alu_op_e;

   typedef enum logic [1:0] {
      SRC_A_PC   = 2'b00,
      SRC_A_REG  = 2'b01,
      SRC_A_ZERO = 2'b10,
      SRC_A_ZR2  = 2'b11
   } src_a_e;

   typedef enum logic [1:0] {
      SRC_B_REG = 2'b00,
      SRC_B_ONE = 2'b01,
      SRC_B_SE  = 2'b10,
      SRC_B_ZE  = 2'b11
   } src_b_e;

   typedef enum logic [1:0] {
      PC_SRC_ALU  = 2'b00,
      PC_SRC_OUT  = 2'b01,
      PC_SRC_JMP  = 2'b10,
      PC_SRC_HOLD = 2'b11
   } pc_src_e;

   typedef enum logic [1:0] {
      WB_ALUOUT = 2'b00,
      WB_MDR    = 2'b01,
      WB_ZE     = 2'b10,
      WB_LUI    = 2'b11
   } wb_sel_e;

   // Codes 1xxx are reserved and produce 0.
   function automatic logic [DATA_W_DEF-1:0] alu_f(
      input logic [3:0]            op,
      input logic [DATA_W_DEF-1:0] a,
      input logic [DATA_W_DEF-1:0] b
   );
      logic [DATA_W_DEF-1:0] r;
      r = '0;
      unique case (op)
         ALU_PASS: r = a;
         ALU_NOT:  r = ~a;
         ALU_ADD:  r = a + b;
         ALU_SUB:  r = a - b;
         ALU_OR:   r = a | b;
         ALU_AND:  r = a & b;
         ALU_XOR:  r = a ^ b;
         ALU_SLT:  r = {{(DATA_W_DEF-1){1'b0}},
                        $signed(a) < $signed(b)};
         default:  r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/multicycle_datapath_if.sv
// Control word, status and memory bus between controller and datapath.
// master = controller/memory side, slave = datapath.
interface multicycle_datapath_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 16
);
   logic [3:0]        alu_op;
   logic [1:0]        pc_source;
   logic [1:0]        alu_src_a;
   logic [1:0]        alu_src_b;
   logic [1:0]        mem_to_reg;
   logic              ir_write;
   logic              pc_write;
   logic              pc_write_cond;
   logic              reg_write;
   logic              mem_write;
   logic              read_sel;
   logic [5:0]        op_out;
   logic              zero;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_we;
   logic [DATA_W-1:0] mem_rdata;
   logic [DATA_W-1:0] pc_out;

   modport master (
      output alu_op, pc_source, alu_src_a, alu_src_b,
      output mem_to_reg, ir_write, pc_write, pc_write_cond,
      output reg_write, mem_write, read_sel, mem_rdata,
      input  op_out, zero, mem_addr, mem_wdata, mem_we, pc_out
   );

   modport slave (
      input  alu_op, pc_source, alu_src_a, alu_src_b,
      input  mem_to_reg, ir_write, pc_write, pc_write_cond,
      input  reg_write, mem_write, read_sel, mem_rdata,
      output op_out, zero, mem_addr, mem_wdata, mem_we, pc_out
   );
endinterface

// File: rtl/multicycle_datapath_regfile_2r1w.sv
// Two async-read, one sync-write register file with async clear.
// REG_ZERO_HARDWIRE_EN: r0 reads 0 and ignores writes.
module regfile_2r1w #(
   parameter int DATA_W = 32,
   parameter int NREG   = 32,
   parameter int RW     = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [RW-1:0]     ra1,
   input  logic [RW-1:0]     ra2,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   input  logic              we,
   input  logic [RW-1:0]     wa,
   input  logic [DATA_W-1:0] wd
);

   logic [DATA_W-1:0] regs [NREG];
   logic              wr_en;

`ifdef REG_ZERO_HARDWIRE_EN
   assign wr_en = we && (wa != '0);
   assign rd1   = (ra1 == '0) ? '0 : regs[ra1];
   assign rd2   = (ra2 == '0) ? '0 : regs[ra2];
`else
   assign wr_en = we;
   assign rd1   = regs[ra1];
   assign rd2   = regs[ra2];
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (wr_en) begin
         regs[wa] <= wd;
      end
   end

endmodule

// File: rtl/multicycle_datapath.sv
// Multicycle datapath: PC/IR/A/B/ALUOut/MDR, ALU and register file.
// Define REG_ZERO_HARDWIRE_EN to hardwire r0 to zero.
module multicycle_datapath
   import multicycle_datapath_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = 16,
   parameter int NREG   = 32
) (
   input  logic                  clk,
   input  logic                  reset_n,
   multicycle_datapath_if.slave  bus
);

   localparam int RW = $clog2(NREG);

   logic [DATA_W-1:0] pc, ir, a_q, b_q, alu_out_q, mdr;
   logic [DATA_W-1:0] rf_a, rf_b;
   logic [DATA_W-1:0] opa, opb, alu_res;
   logic [DATA_W-1:0] pc_next, wb_data;
   logic [DATA_W-1:0] se_imm, ze_imm, lui_imm;
   logic [15:0]       imm;
   logic              pc_en;

   assign imm     = ir[IMM_MSB:IMM_LSB];
   assign se_imm  = {{(DATA_W-16){imm[15]}}, imm};
   assign ze_imm  = {{(DATA_W-16){1'b0}}, imm};
   assign lui_imm = {imm, {(DATA_W-16){1'b0}}};

   regfile_2r1w #(
      .DATA_W (DATA_W),
      .NREG   (NREG)
   ) u_rf (
      .clk     (clk),
      .reset_n (reset_n),
      .ra1     (ir[RS_LSB +: RW]),
      .ra2     (ir[RT_LSB +: RW]),
      .rd1     (rf_a),
      .rd2     (rf_b),
      .we      (bus.reg_write),
      .wa      (ir[RD_LSB +: RW]),
      .wd      (wb_data)
   );

   always_comb begin
      opa = '0;
      unique case (bus.alu_src_a)
         SRC_A_PC:  opa = pc;
         SRC_A_REG: opa = a_q;
         default:   opa = '0;
      endcase
   end

   always_comb begin
      opb = '0;
      unique case (bus.alu_src_b)
         SRC_B_REG: opb = b_q;
         SRC_B_ONE: opb = {{(DATA_W-1){1'b0}}, 1'b1};
         SRC_B_SE:  opb = se_imm;
         SRC_B_ZE:  opb = ze_imm;
         default:   opb = '0;
      endcase
   end

   assign alu_res  = alu_f(bus.alu_op, opa, opb);
   assign bus.zero = (alu_res == '0);

   always_comb begin
      pc_next = pc;
      unique case (bus.pc_source)
         PC_SRC_ALU:  pc_next = alu_res;
         PC_SRC_OUT:  pc_next = alu_out_q;
         PC_SRC_JMP:  pc_next = {pc[DATA_W-1:JT_W], ir[JT_W-1:0]};
         PC_SRC_HOLD: pc_next = pc;
         default:     pc_next = pc;
      endcase
   end

   always_comb begin
      wb_data = alu_out_q;
      unique case (bus.mem_to_reg)
         WB_ALUOUT: wb_data = alu_out_q;
         WB_MDR:    wb_data = mdr;
         WB_ZE:     wb_data = ze_imm;
         WB_LUI:    wb_data = lui_imm;
         default:   wb_data = alu_out_q;
      endcase
   end

   assign pc_en = bus.pc_write | (bus.pc_write_cond & bus.zero);

   // A/B/ALUOut/MDR refresh every cycle; the controller sequences use.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc        <= '0;
         ir        <= '0;
         a_q       <= '0;
         b_q       <= '0;
         alu_out_q <= '0;
         mdr       <= '0;
      end else begin
         a_q       <= rf_a;
         b_q       <= rf_b;
         alu_out_q <= alu_res;
         mdr       <= bus.mem_rdata;
         if (bus.ir_write) ir <= bus.mem_rdata;
         if (pc_en)        pc <= pc_next;
      end
   end

   assign bus.op_out    = ir[OP_MSB:OP_LSB];
   assign bus.mem_addr  = bus.read_sel ? alu_out_q[ADDR_W-1:0]
                                       : pc[ADDR_W-1:0];
   assign bus.mem_wdata = b_q;
   assign bus.mem_we    = bus.mem_write;
   assign bus.pc_out    = pc;

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath acting as controller and memory.
module tb_multicycle_datapath;
   import multicycle_datapath_pkg::*;

   typedef struct packed {
      logic [3:0] op;
      logic [1:0] ps;
      logic [1:0] sa;
      logic [1:0] sb;
      logic [1:0] m2r;
      logic       irw;
      logic       pcw;
      logic       pcwc;
      logic       rw;
      logic       mw;
      logic       rs;
   } ctrl_t;

   typedef struct {
      string       nm;
      logic [15:0] ia;
      logic        ua;
      logic [15:0] ib;
      logic        ub;
      logic [3:0]  op;
      logic [1:0]  sa;
      logic [1:0]  sb;
      logic [31:0] exp;
      logic        z;
   } vec_t;

   localparam logic [31:0] ALU_IR = {6'h0, 5'd0, 5'd2, 16'h9805};

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   multicycle_datapath_if bus ();

   multicycle_datapath dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   logic [31:0] mem [256];
   logic        ovr_en;
   logic [31:0] ovr_data;
   logic        pl_we;
   logic [7:0]  pl_addr;
   logic [31:0] pl_data;

   assign bus.mem_rdata = ovr_en ? ovr_data : mem[bus.mem_addr[7:0]];

   always @(posedge clk) begin
      if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
      if (pl_we) mem[pl_addr] <= pl_data;
   end

   int n_cmp = 0;
   int n_bad = 0;
   vec_t tv [17];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic vec_t mkv(
      input string nm, input logic [15:0] ia, input logic ua,
      input logic [15:0] ib, input logic ub, input logic [3:0] op,
      input logic [1:0] sa, input logic [1:0] sb,
      input logic [31:0] exp, input logic z);
      vec_t v;
      v.nm = nm; v.ia = ia; v.ua = ua; v.ib = ib; v.ub = ub;
      v.op = op; v.sa = sa; v.sb = sb; v.exp = exp; v.z = z;
      return v;
   endfunction

   task automatic drive(input ctrl_t c);
      bus.alu_op        = c.op;
      bus.pc_source     = c.ps;
      bus.alu_src_a     = c.sa;
      bus.alu_src_b     = c.sb;
      bus.mem_to_reg    = c.m2r;
      bus.ir_write      = c.irw;
      bus.pc_write      = c.pcw;
      bus.pc_write_cond = c.pcwc;
      bus.reg_write     = c.rw;
      bus.mem_write     = c.mw;
      bus.read_sel      = c.rs;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step(input ctrl_t c);
      drive(c);
      tick();
   endtask

   task automatic idle();
      ctrl_t c;
      c = '0;
      step(c);
   endtask

   task automatic load_ir(input logic [31:0] w);
      ctrl_t c;
      c = '0;
      c.irw = 1'b1;
      ovr_en = 1'b1;
      ovr_data = w;
      step(c);
      ovr_en = 1'b0;
   endtask

   task automatic li(input logic [4:0] rd, input logic [15:0] imm,
                     input logic up);
      ctrl_t c;
      load_ir({6'h0, rd, 5'd0, imm});
      c = '0;
      c.rw = 1'b1;
      c.m2r = up ? 2'b11 : 2'b10;
      step(c);
   endtask

   task automatic read_reg(input string nm, input logic [4:0] r,
                           input logic [31:0] exp);
      load_ir({6'h0, 5'd0, 5'd0, r, 11'd0});
      idle();
      chk(nm, bus.mem_wdata, exp);
   endtask

   task automatic fetch();
      ctrl_t c;
      c = '0;
      c.irw = 1'b1; c.pcw = 1'b1;
      c.sa = 2'b00; c.sb = 2'b01; c.op = 4'h2; c.ps = 2'b00;
      step(c);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      ctrl_t c;
      tv[0]  = mkv("add",    16'h0005, 0, 16'h0007, 0, 4'h2, 2'b01, 2'b00, 32'h0000_000C, 0);
      tv[1]  = mkv("sub",    16'h0005, 0, 16'h0007, 0, 4'h3, 2'b01, 2'b00, 32'hFFFF_FFFE, 0);
      tv[2]  = mkv("sub_eq", 16'h0009, 0, 16'h0009, 0, 4'h3, 2'b01, 2'b00, 32'h0000_0000, 1);
      tv[3]  = mkv("or",     16'h00F0, 0, 16'h0F0F, 0, 4'h4, 2'b01, 2'b00, 32'h0000_0FFF, 0);
      tv[4]  = mkv("and",    16'h00F0, 0, 16'h0FF0, 0, 4'h5, 2'b01, 2'b00, 32'h0000_00F0, 0);
      tv[5]  = mkv("xor",    16'h00FF, 0, 16'h0F0F, 0, 4'h6, 2'b01, 2'b00, 32'h0000_0FF0, 0);
      tv[6]  = mkv("not",    16'h1234, 0, 16'h0000, 0, 4'h1, 2'b01, 2'b00, 32'hFFFF_EDCB, 0);
      tv[7]  = mkv("pass",   16'hABCD, 1, 16'h0000, 0, 4'h0, 2'b01, 2'b00, 32'hABCD_0000, 0);
      tv[8]  = mkv("slt_t",  16'h8000, 1, 16'h0001, 0, 4'h7, 2'b01, 2'b00, 32'h0000_0001, 0);
      tv[9]  = mkv("slt_f",  16'h0005, 0, 16'h8000, 1, 4'h7, 2'b01, 2'b00, 32'h0000_0000, 1);
      tv[10] = mkv("add_se", 16'h0010, 0, 16'h0000, 0, 4'h2, 2'b01, 2'b10, 32'hFFFF_9815, 0);
      tv[11] = mkv("add_ze", 16'h0010, 0, 16'h0000, 0, 4'h2, 2'b01, 2'b11, 32'h0000_9815, 0);
      tv[12] = mkv("a0_one", 16'h0005, 0, 16'h0007, 0, 4'h2, 2'b10, 2'b01, 32'h0000_0001, 0);
      tv[13] = mkv("a3_sub", 16'h0005, 0, 16'h0007, 0, 4'h3, 2'b11, 2'b01, 32'hFFFF_FFFF, 0);
      tv[14] = mkv("op_8",   16'h0005, 0, 16'h0007, 0, 4'h8, 2'b01, 2'b00, 32'h0000_0000, 1);
      tv[15] = mkv("op_f",   16'h0005, 0, 16'h0007, 0, 4'hF, 2'b01, 2'b00, 32'h0000_0000, 1);
      tv[16] = mkv("wrap",   16'hFFFF, 1, 16'h0001, 1, 4'h2, 2'b01, 2'b00, 32'h0000_0000, 1);

      ovr_en = 1'b0; ovr_data = '0;
      pl_we = 1'b1; pl_addr = 8'h00; pl_data = 32'h4022_1800;
      reset_n = 1'b0;
      c = '0;
      drive(c);
      #2;
      chk("rst_pc", bus.pc_out, 32'h0);
      chk("rst_op", {26'h0, bus.op_out}, 32'h0);
      chk("rst_we", {31'h0, bus.mem_we}, 32'h0);
      @(posedge clk);
      #1 pl_we = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;

      // r2=5, r3=7, then fetch ADD r1,r2,r3 from mem[0]
      li(5'd2, 16'd5, 1'b0);
      li(5'd3, 16'd7, 1'b0);
      chk("fetch_addr", {16'h0, bus.mem_addr}, 32'h0);
      fetch();
      chk("fetch_pc", bus.pc_out, 32'h1);
      chk("fetch_op", {26'h0, bus.op_out}, 32'h10);
      idle();
      chk("rtype_b", bus.mem_wdata, 32'h7);
      c = '0; c.op = 4'h2; c.sa = 2'b01; c.sb = 2'b00;
      drive(c);
      #1 chk("rtype_z", {31'h0, bus.zero}, 32'h0);
      tick();
      c = '0; c.rw = 1'b1; c.m2r = 2'b00;
      step(c);
      read_reg("rtype_r1", 5'd1, 32'd12);

      for (int i = 0; i < 17; i++) begin
         li(5'd2, tv[i].ia, tv[i].ua);
         li(5'd19, tv[i].ib, tv[i].ub);
         load_ir(ALU_IR);
         idle();
         c = '0;
         c.op = tv[i].op; c.sa = tv[i].sa; c.sb = tv[i].sb;
         c.pcw = 1'b1; c.ps = 2'b00;
         drive(c);
         #1 chk({tv[i].nm, "_z"}, {31'h0, bus.zero}, {31'h0, tv[i].z});
         tick();
         chk(tv[i].nm, bus.pc_out, tv[i].exp);
      end

      // BEQ taken then not taken
      li(5'd2, 16'd9, 1'b0);
      li(5'd19, 16'd9, 1'b0);
      load_ir(ALU_IR);
      idle();
      c = '0; c.op = 4'h2; c.sa = 2'b10; c.sb = 2'b11;
      step(c);
      c = '0; c.op = 4'h3; c.sa = 2'b01; c.sb = 2'b00;
      c.pcwc = 1'b1; c.ps = 2'b01;
      drive(c);
      #1 chk("beq_t_z", {31'h0, bus.zero}, 32'h1);
      tick();
      chk("beq_t_pc", bus.pc_out, 32'h0000_9805);
      li(5'd19, 16'd8, 1'b0);
      load_ir(ALU_IR);
      idle();
      c = '0; c.op = 4'h2; c.sa = 2'b10; c.sb = 2'b10;
      step(c);
      c = '0; c.op = 4'h3; c.sa = 2'b01; c.sb = 2'b00;
      c.pcwc = 1'b1; c.ps = 2'b01;
      drive(c);
      #1 chk("beq_n_z", {31'h0, bus.zero}, 32'h0);
      tick();
      chk("beq_n_pc", bus.pc_out, 32'h0000_9805);

      // Jump keeps PC[31:26]; pc_source=11 holds
      li(5'd2, 16'hFC00, 1'b1);
      load_ir({6'h0, 5'd0, 5'd2, 16'h0});
      idle();
      c = '0; c.sa = 2'b01; c.pcw = 1'b1;
      step(c);
      load_ir(32'h0123_4567);
      c = '0; c.pcw = 1'b1; c.ps = 2'b10;
      step(c);
      chk("jump_pc", bus.pc_out, 32'hFD23_4567);
      c = '0; c.pcw = 1'b1; c.ps = 2'b11;
      step(c);
      chk("hold_pc", bus.pc_out, 32'hFD23_4567);

      li(5'd5, 16'hABCD, 1'b0);
      read_reg("li_r5", 5'd5, 32'h0000_ABCD);
      li(5'd6, 16'hABCD, 1'b1);
      read_reg("lui_r6", 5'd6, 32'hABCD_0000);

      // Build 0xDEADBEEF in r10, store to 0x40, load into r11
      li(5'd8, 16'hDEAD, 1'b1);
      li(5'd9, 16'hBEEF, 1'b0);
      load_ir({6'h0, 5'd10, 5'd8, 5'd9, 11'd0});
      idle();
      c = '0; c.op = 4'h4; c.sa = 2'b01; c.sb = 2'b00;
      step(c);
      c = '0; c.rw = 1'b1; c.m2r = 2'b00;
      step(c);
      li(5'd2, 16'h0040, 1'b0);
      load_ir({6'h0, 5'd11, 5'd2, 5'd10, 11'd0});
      idle();
      c = '0; c.sa = 2'b01;
      step(c);
      c = '0; c.sa = 2'b01; c.rs = 1'b1; c.mw = 1'b1;
      drive(c);
      #1;
      chk("sw_addr", {16'h0, bus.mem_addr}, 32'h40);
      chk("sw_we", {31'h0, bus.mem_we}, 32'h1);
      chk("sw_data", bus.mem_wdata, 32'hDEAD_BEEF);
      tick();
      chk("sw_mem", mem[8'h40], 32'hDEAD_BEEF);
      c = '0; c.sa = 2'b01; c.rs = 1'b1;
      step(c);
      c = '0; c.sa = 2'b01; c.rs = 1'b1; c.rw = 1'b1; c.m2r = 2'b01;
      step(c);
      read_reg("lw_r11", 5'd11, 32'hDEAD_BEEF);

      load_ir({6'h0, 5'd0, 5'd2, 5'd10, 11'd0});
      idle();
      c = '0; c.sa = 2'b01;
      step(c);
      c = '0; c.sa = 2'b01; c.rs = 1'b1;
      step(c);
      c = '0; c.sa = 2'b01; c.rs = 1'b1; c.rw = 1'b1; c.m2r = 2'b01;
      step(c);
`ifdef REG_ZERO_HARDWIRE_EN
      read_reg("lw_r0", 5'd0, 32'h0);
`else
      read_reg("lw_r0", 5'd0, 32'hDEAD_BEEF);
`endif

      // Mid-cycle async reset with PC=0x25
      li(5'd2, 16'h0025, 1'b0);
      load_ir({6'h3F, 5'd0, 5'd2, 16'h0});
      idle();
      c = '0; c.sa = 2'b01; c.pcw = 1'b1;
      step(c);
      chk("pre_rst_pc", bus.pc_out, 32'h25);
      chk("pre_rst_op", {26'h0, bus.op_out}, 32'h3F);
      c = '0;
      drive(c);
      #2 reset_n = 1'b0;
      #1;
      chk("mid_rst_pc", bus.pc_out, 32'h0);
      chk("mid_rst_op", {26'h0, bus.op_out}, 32'h0);
      chk("mid_rst_we", {31'h0, bus.mem_we}, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      fetch();
      chk("post_rst_pc", bus.pc_out, 32'h1);
      chk("post_rst_op", {26'h0, bus.op_out}, 32'h10);
      read_reg("post_rst_r2", 5'd2, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
